// File: rtl/clint.sv
// Core-local trap sequencer: turns ecall, mret and machine-timer interrupts at commit into
// one-CSR-per-cycle mepc/mcause/mstatus updates followed by a single-cycle PC redirect.
module clint #(
    parameter logic [1:0] RESET_MPP = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [63:0] pc_i,
    input  logic        inst_ecall_i,
    input  logic        inst_mret_i,
    input  logic [63:0] csr_mtvec_i,
    input  logic [63:0] csr_mepc_i,
    input  logic [63:0] csr_mstatus_i,
    input  logic        global_int_en_i,
    input  logic        mtime_int_en_i,
    input  logic        mtime_int_pend_i,
    output logic        clint_csr_wen_o,
    output logic [11:0] clint_csr_waddr_o,
    output logic [63:0] clint_csr_wdata_o,
    output logic        hold_o,
    output logic        jump_o,
    output logic [63:0] jump_addr_o
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWMepc    = 3'd1;
    localparam logic [2:0] StWMcause  = 3'd2;
    localparam logic [2:0] StWMstatus = 3'd3;
    localparam logic [2:0] StWMret    = 3'd4;
    localparam logic [2:0] StJump     = 3'd5;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [63:0] CauseMtimer = 64'h8000_0000_0000_0007;
    localparam logic [63:0] CauseEcall  = 64'd11;

    logic [2:0]  state_q, state_d;
    logic [63:0] epc_q, epc_d;
    logic [63:0] cause_q, cause_d;
    logic [63:0] tgt_q, tgt_d;
    logic        irq;
    logic        event_hit;
    logic [63:0] mstatus_trap;
    logic [63:0] mstatus_ret;

    assign irq       = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    assign event_hit = valid_i & (irq | inst_ecall_i | inst_mret_i);

    // Stall from the detection cycle onward so the CPU never contends for the CSR port.
    assign hold_o = (state_q != StIdle) | event_hit;

    always_comb begin
        mstatus_trap         = csr_mstatus_i;
        mstatus_trap[7]      = csr_mstatus_i[3];
        mstatus_trap[3]      = 1'b0;
        mstatus_trap[12:11]  = RESET_MPP;

        mstatus_ret          = csr_mstatus_i;
        mstatus_ret[3]       = csr_mstatus_i[7];
        mstatus_ret[7]       = 1'b1;
        mstatus_ret[12:11]   = RESET_MPP;
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        tgt_d   = tgt_q;
        case (state_q)
            StIdle: begin
                if (valid_i) begin
                    if (irq) begin
                        epc_d   = pc_i;
                        cause_d = CauseMtimer;
                        state_d = StWMepc;
                    end else if (inst_ecall_i) begin
                        epc_d   = pc_i;
                        cause_d = CauseEcall;
                        state_d = StWMepc;
                    end else if (inst_mret_i) begin
                        state_d = StWMret;
                    end
                end
            end
            StWMepc:    state_d = StWMcause;
            StWMcause:  state_d = StWMstatus;
            StWMstatus: begin
                // Direct mode only: the low mode bits of mtvec are dropped.
                tgt_d   = csr_mtvec_i & ~64'h3;
                state_d = StJump;
            end
            StWMret: begin
                tgt_d   = csr_mepc_i;
                state_d = StJump;
            end
            StJump:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        clint_csr_wen_o   = 1'b0;
        clint_csr_waddr_o = 12'h000;
        clint_csr_wdata_o = 64'd0;
        jump_o            = 1'b0;
        jump_addr_o       = 64'd0;
        case (state_q)
            StWMepc: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = CsrMepc;
                clint_csr_wdata_o = epc_q;
            end
            StWMcause: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = CsrMcause;
                clint_csr_wdata_o = cause_q;
            end
            StWMstatus: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = CsrMstatus;
                clint_csr_wdata_o = mstatus_trap;
            end
            StWMret: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = CsrMstatus;
                clint_csr_wdata_o = mstatus_ret;
            end
            StJump: begin
                jump_o      = 1'b1;
                jump_addr_o = tgt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            epc_q   <= 64'd0;
            cause_q <= 64'd0;
            tgt_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_clint.sv
// Randomized bench for clint: a per-cycle expected-output queue built from the trap rules
// is compared against the DUT, plus directed cases for the documented scenarios.
module tb_clint;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [63:0] pc_i = 64'd0;
    logic        inst_ecall_i = 1'b0;
    logic        inst_mret_i = 1'b0;
    logic [63:0] csr_mtvec_i = 64'd0;
    logic [63:0] csr_mepc_i = 64'd0;
    logic [63:0] csr_mstatus_i = 64'd0;
    logic        global_int_en_i = 1'b0;
    logic        mtime_int_en_i = 1'b0;
    logic        mtime_int_pend_i = 1'b0;
    logic        clint_csr_wen_o;
    logic [11:0] clint_csr_waddr_o;
    logic [63:0] clint_csr_wdata_o;
    logic        hold_o;
    logic        jump_o;
    logic [63:0] jump_addr_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        hold;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        jump;
        logic [63:0] jaddr;
    } exp_t;

    exp_t exp_q[$];

    clint #(.RESET_MPP(2'b11)) dut (
        .clk               (clk),
        .rst               (rst),
        .valid_i           (valid_i),
        .pc_i              (pc_i),
        .inst_ecall_i      (inst_ecall_i),
        .inst_mret_i       (inst_mret_i),
        .csr_mtvec_i       (csr_mtvec_i),
        .csr_mepc_i        (csr_mepc_i),
        .csr_mstatus_i     (csr_mstatus_i),
        .global_int_en_i   (global_int_en_i),
        .mtime_int_en_i    (mtime_int_en_i),
        .mtime_int_pend_i  (mtime_int_pend_i),
        .clint_csr_wen_o   (clint_csr_wen_o),
        .clint_csr_waddr_o (clint_csr_waddr_o),
        .clint_csr_wdata_o (clint_csr_wdata_o),
        .hold_o            (hold_o),
        .jump_o            (jump_o),
        .jump_addr_o       (jump_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic hold, input logic wen, input logic [11:0] waddr,
                                input logic [63:0] wdata, input logic jump,
                                input logic [63:0] jaddr);
        exp_t e;
        e.hold = hold; e.wen = wen; e.waddr = waddr;
        e.wdata = wdata; e.jump = jump; e.jaddr = jaddr;
        return e;
    endfunction

    // Reference mstatus arithmetic: clear MIE, MPIE and MPP, then OR in the new fields.
    function automatic logic [63:0] ms_trap(input logic [63:0] ms);
        return (ms & ~64'h1888) | (64'(ms[3]) << 7) | (64'd3 << 11);
    endfunction

    function automatic logic [63:0] ms_ret(input logic [63:0] ms);
        return (ms & ~64'h1888) | (64'(ms[7]) << 3) | 64'h80 | (64'd3 << 11);
    endfunction

    task automatic compare(input exp_t e, input string tag);
        check({tag, ".hold"},  64'(hold_o),            64'(e.hold));
        check({tag, ".wen"},   64'(clint_csr_wen_o),   64'(e.wen));
        check({tag, ".waddr"}, 64'(clint_csr_waddr_o), 64'(e.waddr));
        check({tag, ".wdata"}, clint_csr_wdata_o,      e.wdata);
        check({tag, ".jump"},  64'(jump_o),            64'(e.jump));
        check({tag, ".jaddr"}, jump_addr_o,            e.jaddr);
    endtask

    // Apply one cycle of commit-side inputs, then check against the model. CSR inputs are
    // only changed by the caller while no sequence is pending.
    task automatic drive_cycle(input logic v, input logic [63:0] pc, input logic ec,
                               input logic mr, input logic gie, input logic mtie,
                               input logic mtip, input string tag);
        exp_t e;
        logic irq;
        @(negedge clk);
        valid_i = v; pc_i = pc; inst_ecall_i = ec; inst_mret_i = mr;
        global_int_en_i = gie; mtime_int_en_i = mtie; mtime_int_pend_i = mtip;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else begin
            irq = gie & mtie & mtip;
            e = mk(1'b0, 1'b0, 12'h0, 64'd0, 1'b0, 64'd0);
            if (v && (irq || ec)) begin
                e.hold = 1'b1;
                exp_q.push_back(mk(1'b1, 1'b1, 12'h341, pc, 1'b0, 64'd0));
                exp_q.push_back(mk(1'b1, 1'b1, 12'h342,
                                   irq ? 64'h8000_0000_0000_0007 : 64'd11, 1'b0, 64'd0));
                exp_q.push_back(mk(1'b1, 1'b1, 12'h300, ms_trap(csr_mstatus_i), 1'b0, 64'd0));
                exp_q.push_back(mk(1'b1, 1'b0, 12'h0, 64'd0, 1'b1,
                                   {csr_mtvec_i[63:2], 2'b00}));
            end else if (v && mr) begin
                e.hold = 1'b1;
                exp_q.push_back(mk(1'b1, 1'b1, 12'h300, ms_ret(csr_mstatus_i), 1'b0, 64'd0));
                exp_q.push_back(mk(1'b1, 1'b0, 12'h0, 64'd0, 1'b1, csr_mepc_i));
            end
        end
        compare(e, tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        // Reset state
        #1;
        compare(mk(1'b0, 1'b0, 12'h0, 64'd0, 1'b0, 64'd0), "reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(2, "post_reset");

        // ecall directed
        csr_mtvec_i = 64'h8000_0007; csr_mstatus_i = 64'h1808; csr_mepc_i = 64'h0;
        drive_cycle(1'b1, 64'h8000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ecall_T0");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ecall_T1");
        check("ecall_mepc_const", clint_csr_wdata_o, 64'h8000_0100);
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ecall_T2");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ecall_T3");
        check("ecall_mstatus_const", clint_csr_wdata_o, 64'h1880);
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ecall_T4");
        check("ecall_jump_const", jump_addr_o, 64'h8000_0004);
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ecall_T5");

        // mret directed
        csr_mepc_i = 64'h8000_0104; csr_mstatus_i = 64'h1880;
        drive_cycle(1'b1, 64'h8000_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mret_T0");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mret_T1");
        check("mret_mstatus_const", clint_csr_wdata_o, 64'h1888);
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mret_T2");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mret_T3");

        // Timer interrupt on a plain instruction
        csr_mstatus_i = 64'h1888;
        drive_cycle(1'b1, 64'h8000_0200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "irq_T0");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "irq_T1");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "irq_T2");
        check("irq_cause_const", clint_csr_wdata_o, 64'h8000_0000_0000_0007);
        idle_cycles(3, "irq_tail");

        // ecall with irq in the same cycle, then MIE=0 with MTIP pending
        drive_cycle(1'b1, 64'h8000_0300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "both_T0");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "both_T1");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "both_T2");
        idle_cycles(3, "both_tail");
        drive_cycle(1'b1, 64'h8000_0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "mie_off");
        check("mie_off_hold", 64'(hold_o), 64'd0);

        // valid_i low masks both ecall and irq
        drive_cycle(1'b0, 64'h8000_0500, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "invalid");
        check("invalid_hold", 64'(hold_o), 64'd0);

        // Reset during W_MCAUSE
        drive_cycle(1'b1, 64'h8000_0600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_T0");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_T1");
        drive_cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_T2");
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        compare(mk(1'b0, 1'b0, 12'h0, 64'd0, 1'b0, 64'd0), "rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        idle_cycles(5, "rst_after");
        drive_cycle(1'b1, 64'h8000_0700, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_new_T0");
        idle_cycles(5, "rst_new_seq");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
                csr_mtvec_i   = {$urandom, $urandom};
                csr_mepc_i    = {$urandom, $urandom};
                csr_mstatus_i = {$urandom, $urandom};
            end
            drive_cycle($urandom_range(0, 9) < 7, {$urandom, $urandom},
                        $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) == 0, "rand");
        end
        idle_cycles(6, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local trap sequencer. Sits between the commit point of the pipeline and the CSR file's second write port. It detects ecall, mret and machine-timer interrupts on the committing instruction, stalls the pipeline, and performs the required mepc/mcause/mstatus updates one CSR per cycle. It then issues a single-cycle PC redirect to mtvec or mepc.

## Interface
- RESET_MPP, 2'b11, value written to mstatus.MPP[12:11] on trap entry and on mret.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  a real instruction is at the commit point this cycle.
- pc_i  in  64  PC of that instruction.
- inst_ecall_i  in  1  committing instruction is ecall.
- inst_mret_i  in  1  committing instruction is mret.
- csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  64  current values from the CSR file.
- global_int_en_i  in  1  mstatus.MIE.
- mtime_int_en_i  in  1  mie.MTIE.
- mtime_int_pend_i  in  1  mip.MTIP.
- clint_csr_wen_o  out  1  CSR write strobe.
- clint_csr_waddr_o  out  12  CSR write address.
- clint_csr_wdata_o  out  64  CSR write data.
- hold_o  out  1  stall the pipeline and suppress the CPU CSR write port.
- jump_o  out  1  one-cycle PC redirect.
- jump_addr_o  out  64  redirect target.

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, JUMP.
- Interrupt condition: irq = global_int_en_i & mtime_int_en_i & mtime_int_pend_i.
- IDLE event priority, highest first, sampled only when valid_i = 1:
  - irq: capture epc_q = pc_i and cause_q = 64'h8000_0000_0000_0007. The instruction is squashed and re-executes after return. Next state W_MEPC.
  - inst_ecall_i: capture epc_q = pc_i and cause_q = 64'd11. Next state W_MEPC.
  - inst_mret_i: next state W_MRET.
- Per-state CSR writes:
  - W_MEPC: wen = 1, waddr = 0x341, wdata = epc_q. Next state W_MCAUSE.
  - W_MCAUSE: wen = 1, waddr = 0x342, wdata = cause_q. Next state W_MSTATUS.
  - W_MSTATUS: wen = 1, waddr = 0x300. wdata = csr_mstatus_i with bit 7 (MPIE) = csr_mstatus_i[3], bit 3 (MIE) = 0, [12:11] = RESET_MPP, all other bits unchanged. Latch tgt_q = {csr_mtvec_i[63:2], 2'b00} (direct mode only). Next state JUMP.
  - W_MRET: wen = 1, waddr = 0x300. wdata = csr_mstatus_i with bit 3 = csr_mstatus_i[7], bit 7 = 1, [12:11] = RESET_MPP. Latch tgt_q = csr_mepc_i. Next state JUMP.
  - JUMP: jump_o = 1, jump_addr_o = tgt_q, wen = 0. Next state IDLE.
- hold_o = (state != IDLE) | (IDLE & valid_i & (irq | inst_ecall_i | inst_mret_i)).
- wen/waddr/wdata/jump_o decode from state only (Moore). waddr and wdata are 0 when wen = 0.
- Events arriving while state != IDLE are ignored. The pipeline is held, so none are lost.
- The CSR file gives its CPU port priority, so the CPU must not write while hold_o = 1. hold_o guarantees exclusivity.

## Timing
- Reset (asynchronous, immediate): state = IDLE; epc_q, cause_q, tgt_q = 0. All outputs 0; hold_o follows its combinational IDLE term.
- Trap latency: detect at cycle T. Writes occur at T+1 (mepc), T+2 (mcause), T+3 (mstatus). jump_o pulses at T+4. hold_o stays high T through T+4 and is low at T+5 unless a new event is present.
- mret latency: detect at T, mstatus write at T+1, jump at T+2.
- The mstatus read in W_MSTATUS/W_MRET takes the CSR file's registered value. The earlier writes in the sequence do not touch mstatus, so no forwarding is needed.
- Reset asserted mid-sequence: abort immediately. No further CSR writes or jump; partially written CSRs are left as written.
- After mret the restored MIE is visible at T+2. An irq can be taken on the first valid instruction after the jump (T+3 or later).

## Test plan
- ecall with pc_i = 0x8000_0100, mtvec = 0x8000_0007, mstatus = 0x1808:
  - T+1 writes 0x341 ← 0x8000_0100.
  - T+2 writes 0x342 ← 11.
  - T+3 writes 0x300 ← 0x1880.
  - T+4 jump_o = 1, jump_addr_o = 0x8000_0004.
  - hold_o high for 5 cycles.
- mret with mepc = 0x8000_0104, mstatus = 0x1880: T+1 writes 0x300 ← 0x1888; T+2 jumps to 0x8000_0104; hold_o high for 3 cycles.
- Timer interrupt (MIE = 1, MTIE = 1, MTIP = 1) on a plain instruction at 0x8000_0200: writes mcause 0x8000_0000_0000_0007 and mepc 0x8000_0200, then jumps to mtvec.
- ecall and irq in the same cycle: the interrupt cause is written. Then set MIE = 0 with MTIP = 1 and issue a valid instruction: no trap, hold_o = 0.
- Reset asserted during W_MCAUSE: outputs 0 immediately. After release, no further writes and no jump; a new ecall runs a full clean sequence.
- valid_i = 0 with inst_ecall_i = 1 and irq = 1: stays in IDLE, hold_o = 0.
